// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
// Optional burst mode is selected with the MUX8_ARB_BURST_EN macro.
package mux8_rr_arbiter_pkg;

   localparam int NREQ   = 8;
   localparam int SEL_W  = 3;
   localparam int DATA_W = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Eight-way, 16-bit wide data selector for the shared bus.
module Mux8Way16
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   input  logic [DATA_W-1:0] e,
   input  logic [DATA_W-1:0] f,
   input  logic [DATA_W-1:0] g,
   input  logic [DATA_W-1:0] h,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] out
);

   always_comb begin
      unique case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end

endmodule

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin picker: first set bit of mask scanning upward
// from ptr with wrap-around from 7 back to 0.
module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [2*NREQ-1:0] doubled;
   logic [NREQ-1:0]   rotated;
   logic [SEL_W-1:0]  offset;

   // Rotating the doubled mask puts position ptr at bit 0, so the
   // lowest set bit of the rotated word is the round-robin winner.
   assign doubled = {mask, mask};
   assign rotated = NREQ'(doubled >> ptr);

   always_comb begin
      offset = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = SEL_W'(k);
         end
      end
   end

   assign found = |mask;
   assign idx   = ptr + offset;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit bus among eight requesters with a
// valid/ready handshake. Define MUX8_ARB_BURST_EN for multi-transfer grants.
module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   input  logic [DATA_W-1:0] e,
   input  logic [DATA_W-1:0] f,
   input  logic [DATA_W-1:0] g,
   input  logic [DATA_W-1:0] h,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic [NREQ-1:0]   gnt,
   output logic [SEL_W-1:0]  sel,
   output logic [NREQ-1:0]   ack
);

   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("BURST_LEN must be at least 1");
   end

   arb_state_t       state;
   arb_state_t       state_n;
   logic [SEL_W-1:0] sel_n;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_n;
   logic [NREQ-1:0]  gnt_n;
   logic             xfer;
   logic             drop_grant;
   logic [NREQ-1:0]  pick_mask;
   logic [SEL_W-1:0] pick_start;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;

`ifdef MUX8_ARB_BURST_EN
   localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BURST_MAX = BURST_LEN - 1;

   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_cnt_n;
`endif

   assign out_valid = (state == ST_GRANT) && req[sel];
   assign xfer      = out_valid && out_ready;
   assign ack       = gnt & {NREQ{xfer}};

   // From idle the whole request vector competes starting at ptr; while a
   // grant is active only the others compete, starting just after the holder.
   always_comb begin
      pick_mask  = req;
      pick_start = ptr;
      if (state == ST_GRANT) begin
         pick_mask  = req & ~gnt;
         pick_start = sel + 3'd1;
      end
   end

   rr_pick8 u_pick (
      .mask  (pick_mask),
      .ptr   (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   Mux8Way16 u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f),
      .g   (g),
      .h   (h),
      .sel (sel),
      .out (out)
   );

   always_comb begin
      state_n    = state;
      sel_n      = sel;
      gnt_n      = gnt;
      ptr_n      = ptr;
      drop_grant = 1'b0;
`ifdef MUX8_ARB_BURST_EN
      burst_cnt_n = burst_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_n = ST_GRANT;
               sel_n   = pick_idx;
               gnt_n   = onehot(pick_idx);
            end
         end
         default: begin
            // A holder that withdraws its request without a transfer is released too.
            if (xfer) begin
`ifdef MUX8_ARB_BURST_EN
               if (burst_cnt < CNT_W'(BURST_MAX)) begin
                  burst_cnt_n = burst_cnt + 1'b1;
               end else begin
                  drop_grant = 1'b1;
               end
`else
               drop_grant = 1'b1;
`endif
            end else if (!req[sel]) begin
               drop_grant = 1'b1;
            end

            if (drop_grant) begin
               ptr_n = sel + 3'd1;
`ifdef MUX8_ARB_BURST_EN
               burst_cnt_n = '0;
`endif
               if (pick_found) begin
                  sel_n = pick_idx;
                  gnt_n = onehot(pick_idx);
               end else begin
                  state_n = ST_IDLE;
                  gnt_n   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         sel   <= '0;
         gnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         gnt   <= gnt_n;
         ptr   <= ptr_n;
      end
   end

`ifdef MUX8_ARB_BURST_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= '0;
      end else begin
         burst_cnt <= burst_cnt_n;
      end
   end
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios followed by
// randomized requesters, all compared against a behavioural arbitration model.
module tb_mux8_rr_arbiter;

   localparam int BURST_LEN = 4;
`ifdef MUX8_ARB_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  req;
   logic [15:0] dw [8];
   logic        out_ready;
   logic [15:0] out;
   logic        out_valid;
   logic [7:0]  gnt;
   logic [2:0]  sel;
   logic [7:0]  ack;

   int total = 0;
   int bad   = 0;

   // Model state: whether someone holds the bus, who, where the scan resumes,
   // and how many transfers the holder has made in its current grant.
   bit         m_active;
   int         m_sel;
   int         m_ptr;
   int         m_cnt;
   logic [7:0] exp_ack;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.BURST_LEN(BURST_LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a         (dw[0]),
      .b         (dw[1]),
      .c         (dw[2]),
      .d         (dw[3]),
      .e         (dw[4]),
      .f         (dw[5]),
      .g         (dw[6]),
      .h         (dw[7]),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .gnt       (gnt),
      .sel       (sel),
      .ack       (ack)
   );

   function automatic int rr_first(input logic [7:0] m, input int start);
      for (int k = 0; k < 8; k++) begin
         if (m[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      logic [7:0] eg;
      logic       ev;
      eg      = m_active ? (8'h01 << m_sel) : 8'h00;
      ev      = m_active && req[m_sel];
      exp_ack = (ev && out_ready) ? eg : 8'h00;
      check("gnt",       {8'h00, gnt},         {8'h00, eg});
      check("sel",       {13'h0, sel},         16'(m_sel));
      check("out_valid", {15'h0, out_valid},   {15'h0, ev});
      check("ack",       {8'h00, ack},         {8'h00, exp_ack});
      check("out",       out,                  dw[m_sel]);
   endtask

   task automatic model_step();
      int  w;
      bit  done;
      if (reset) begin
         m_active = 1'b0;
         m_sel    = 0;
         m_ptr    = 0;
         m_cnt    = 0;
      end else if (!m_active) begin
         w = rr_first(req, m_ptr);
         if (w >= 0) begin
            m_active = 1'b1;
            m_sel    = w;
         end
      end else begin
         done = 1'b0;
         if (req[m_sel] && out_ready) begin
            if (BURST_ON && m_cnt < BURST_LEN - 1) m_cnt++;
            else done = 1'b1;
         end else if (!req[m_sel]) begin
            done = 1'b1;
         end
         if (done) begin
            m_ptr = (m_sel + 1) % 8;
            m_cnt = 0;
            w = rr_first(req & ~(8'h01 << m_sel), m_ptr);
            if (w >= 0) m_sel = w;
            else m_active = 1'b0;
         end
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] r, input logic rdy, input logic rst);
      @(negedge clk);
      req       = r;
      out_ready = rdy;
      reset     = rst;
      #1;
      check_output();
      model_step();
   endtask

   initial begin
      logic [7:0] hold;

      reset     = 1'b1;
      req       = 8'h00;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) dw[i] = 16'($urandom);
      repeat (2) @(posedge clk);
      m_active = 1'b0;
      m_sel    = 0;
      m_ptr    = 0;
      m_cnt    = 0;

      $display("[TB] reset held with all requests");
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(8'hFF, 1'b1, 1'b1);
         check("t1_gnt", {8'h00, gnt}, 16'h0000);
         check("t1_ack", {8'h00, ack}, 16'h0000);
      end

      $display("[TB] single requester c");
      dw[2] = 16'h1234;
      apply_stimulus(8'h04, 1'b1, 1'b0);
      apply_stimulus(8'h04, 1'b1, 1'b0);
      check("t2_gnt", {8'h00, gnt}, 16'h0004);
      check("t2_sel", {13'h0, sel}, 16'h0002);
      check("t2_out", out, 16'h1234);
      check("t2_ack", {8'h00, ack}, 16'h0004);
      apply_stimulus(8'h00, 1'b1, 1'b0);
      check("t2_idle", {8'h00, gnt}, 16'h0000);

      $display("[TB] eight continuous requesters");
      apply_stimulus(8'hFF, 1'b0, 1'b1);
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) begin
         apply_stimulus(8'hFF, 1'b1, 1'b0);
         check("t3_sel", {13'h0, sel}, 16'(k % 8));
         check("t3_ack", {8'h00, ack}, 16'(8'h01 << (k % 8)));
      end

      $display("[TB] stalled consumer with a and h");
      apply_stimulus(8'hFF, 1'b0, 1'b1);
      apply_stimulus(8'h81, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         apply_stimulus(8'h81, 1'b0, 1'b0);
         check("t4_hold_gnt", {8'h00, gnt}, 16'h0001);
         check("t4_hold_out", out, dw[0]);
         check("t4_hold_ack", {8'h00, ack}, 16'h0000);
      end
      apply_stimulus(8'h81, 1'b1, 1'b0);
      check("t4_ack_a", {8'h00, ack}, 16'h0001);
      apply_stimulus(8'h81, 1'b1, 1'b0);
      check("t4_gnt_h", {8'h00, gnt}, 16'h0080);
      apply_stimulus(8'h81, 1'b0, 1'b0);
      check("t4_wrap", {8'h00, gnt}, 16'h0001);

      $display("[TB] reset during a stalled grant");
      apply_stimulus(8'h00, 1'b0, 1'b1);
      apply_stimulus(8'h10, 1'b0, 1'b0);
      apply_stimulus(8'h10, 1'b0, 1'b0);
      check("t5_gnt", {8'h00, gnt}, 16'h0010);
      apply_stimulus(8'h10, 1'b0, 1'b1);
      check("t5_noack", {8'h00, ack}, 16'h0000);
      apply_stimulus(8'h10, 1'b0, 1'b0);
      check("t5_cleared", {8'h00, gnt}, 16'h0000);
      apply_stimulus(8'h10, 1'b0, 1'b0);
      check("t5_regrant", {8'h00, gnt}, 16'h0010);

      $display("[TB] two continuous requesters");
      apply_stimulus(8'h00, 1'b0, 1'b1);
      apply_stimulus(8'h03, 1'b1, 1'b0);
      for (int n = 0; n < 16; n++) begin
         int exp_w;
         exp_w = BURST_ON ? ((n / BURST_LEN) % 2) : (n % 2);
         apply_stimulus(8'h03, 1'b1, 1'b0);
         check("t6_sel", {13'h0, sel}, 16'(exp_w));
         check("t6_ack", {8'h00, ack}, 16'(8'h01 << exp_w));
      end

      $display("[TB] randomized requesters");
      apply_stimulus(8'h00, 1'b0, 1'b1);
      hold = 8'h00;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic rst_now;
         logic rdy_now;
         rst_now = ($urandom_range(0, 199) == 0);
         rdy_now = rst_now ? 1'b0 : ($urandom_range(0, 3) != 0);
         apply_stimulus(hold, rdy_now, rst_now);
         for (int i = 0; i < 8; i++) begin
            if (exp_ack[i]) begin
               hold[i] = 1'($urandom_range(0, 1));
               dw[i]   = 16'($urandom);
            end else if (!hold[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  hold[i] = 1'b1;
                  dw[i]   = 16'($urandom);
               end
            end else if ($urandom_range(0, 63) == 0) begin
               hold[i] = 1'b0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
